credit_link_transmitter: RTL and testbench

//  Transmit end of a credit-based inter-region channel. Upstream logic writes words with a FIFO-style handshake.

---
 rtl/credit_link_transmitter_if.sv | 30 +++
 rtl/credit_link_transmitter.sv | 114 +++++++++++
 tb/tb_credit_link_transmitter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/credit_link_transmitter_if.sv
// Signal bundle for the transmit side of a credit-based channel.
// Carries the upstream FIFO-style write handshake, the launched link
// word, the returned-credit pulse and the credit status outputs.
interface credit_link_transmitter_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int CREDIT_WIDTH = 5
);

   logic                    if_write;
   logic [DATA_WIDTH-1:0]   if_din;
   logic                    if_full_n;
   logic                    link_valid;
   logic [DATA_WIDTH-1:0]   link_data;
   logic                    credit_return;
   logic [CREDIT_WIDTH-1:0] credit_cnt;
   logic                    credit_overflow;

   // Environment side: writes words, returns credits, watches the link.
   modport master (
      output if_write, if_din, credit_return,
      input  if_full_n, link_valid, link_data, credit_cnt, credit_overflow
   );

   // Transmitter side: accepts words, launches them, counts credits.
   modport slave (
      input  if_write, if_din, credit_return,
      output if_full_n, link_valid, link_data, credit_cnt, credit_overflow
   );

endinterface

// File: rtl/credit_link_transmitter.sv
// Transmit end of a credit-based inter-region channel.
// Words written upstream are launched onto a ready-less link; each launch
// consumes one credit and each returned credit (optionally delayed through
// a short register pipe) restores one. The full flag is a pure register
// so the upstream write path never sees a combinational path from inputs.
module credit_link_transmitter #(
   parameter int DATA_WIDTH   = 32,
   parameter int CREDITS      = 24,
   parameter int CREDIT_WIDTH = $clog2(CREDITS + 1),
   parameter int OUTPUT_REG   = 1,
   parameter int CREDIT_PIPE  = 0
) (
   input logic                      clk,
   input logic                      reset,
   credit_link_transmitter_if.slave link
);

   localparam logic [CREDIT_WIDTH-1:0] MaxCredits = CREDIT_WIDTH'(CREDITS);

   logic                    accept;
   logic                    creditIn;
   logic [CREDIT_WIDTH-1:0] cnt_q, cnt_d;
   logic                    fullN_q, fullN_d;
   logic                    overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   // A word is taken only while the registered flag says a credit exists,
   // which also guarantees the counter can never go below zero.
   assign accept = link.if_write & fullN_q;

   generate
      if (CREDIT_PIPE == 0) begin : gNoPipe
         assign creditIn = link.credit_return;
      end else begin : gPipe
         logic [CREDIT_PIPE-1:0] pipe_q, pipe_d;

         // Shift the returned-credit pulse along the delay line.
         always_comb begin
            pipe_d    = pipe_q << 1;
            pipe_d[0] = link.credit_return;
         end

         // Delay-line registers; cleared so no phantom credits survive reset.
         always_ff @(posedge clk) begin
            if (reset) pipe_q <= '0;
            else       pipe_q <= pipe_d;
         end

         assign creditIn = pipe_q[CREDIT_PIPE-1];
      end
   endgenerate

   // Credit arithmetic: spend on accept, refund on return, saturate at the
   // receiver depth and flag a return that would exceed it.
   always_comb begin
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      if (accept && !creditIn) begin
         cnt_d = cnt_q - CREDIT_WIDTH'(1);
      end else if (!accept && creditIn) begin
         if (cnt_q == MaxCredits) overflow_d = 1'b1;
         else                     cnt_d      = cnt_q + CREDIT_WIDTH'(1);
      end
      fullN_d = (cnt_d != '0);
   end

   // Counter, full flag and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= MaxCredits;
         fullN_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         fullN_q    <= fullN_d;
         overflow_q <= overflow_d;
      end
   end

   // Capture the launched word so the link data holds between launches.
   always_comb begin
      data_d = data_q;
      if (accept) data_d = link.if_din;
   end

   // Last-launched-word register.
   always_ff @(posedge clk) begin
      if (reset) data_q <= '0;
      else       data_q <= data_d;
   end

   generate
      if (OUTPUT_REG != 0) begin : gRegOut
         logic valid_q;

         // Registered launch: accepted word appears on the link one cycle later.
         always_ff @(posedge clk) begin
            if (reset) valid_q <= 1'b0;
            else       valid_q <= accept;
         end

         assign link.link_valid = valid_q;
         assign link.link_data  = data_q;
      end else begin : gPassOut
         assign link.link_valid = accept;
         assign link.link_data  = accept ? link.if_din : data_q;
      end
   endgenerate

   assign link.if_full_n       = fullN_q;
   assign link.credit_cnt      = cnt_q;
   assign link.credit_overflow = overflow_q;

endmodule

// File: tb/tb_credit_link_transmitter.sv
// Bench for credit_link_transmitter: directed scenarios on a small
// registered-output instance, a pass-through instance, and a long
// randomized run with a delayed credit path against a queue-based model.
module tb_credit_link_transmitter;

   localparam int DW       = 32;
   localparam int C0       = 4;
   localparam int CW0      = 3;
   localparam int C1       = 4;
   localparam int PIPE1    = 2;
   localparam int C2       = 2;
   localparam int CW2      = 2;
   localparam int NumWords = 10000;
   localparam int MaxCycle = 50000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   credit_link_transmitter_if #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW0)) if0 ();
   credit_link_transmitter_if #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW0)) if1 ();
   credit_link_transmitter_if #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW2)) if2 ();

   credit_link_transmitter #(.DATA_WIDTH(DW), .CREDITS(C0), .CREDIT_WIDTH(CW0),
      .OUTPUT_REG(1), .CREDIT_PIPE(0)) dut0 (.clk(clk), .reset(reset), .link(if0));
   credit_link_transmitter #(.DATA_WIDTH(DW), .CREDITS(C1), .CREDIT_WIDTH(CW0),
      .OUTPUT_REG(1), .CREDIT_PIPE(PIPE1)) dut1 (.clk(clk), .reset(reset), .link(if1));
   credit_link_transmitter #(.DATA_WIDTH(DW), .CREDITS(C2), .CREDIT_WIDTH(CW2),
      .OUTPUT_REG(0), .CREDIT_PIPE(0)) dut2 (.clk(clk), .reset(reset), .link(if2));

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) cyc();
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL reset_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
      checks++; if (if0.if_full_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_full_n actual=%b required=0", if0.if_full_n); end
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", if0.link_valid); end
      checks++; if (if0.link_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data actual=%h required=0", if0.link_data); end
      checks++; if (if0.credit_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf actual=%b required=0", if0.credit_overflow); end
      reset = 1'b0;
      if0.if_write = 1'b1;
      if0.if_din   = 32'd0;
      cyc();
      checks++; if (if0.if_full_n !== 1'b1) begin failures++; $display("[TB] FAIL release_full_n actual=%b required=1", if0.if_full_n); end
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL release_valid actual=%b required=0", if0.link_valid); end
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL release_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
   endtask

   task automatic test_fill();
      for (int k = 0; k < C0; k++) begin
         cyc();
         checks++; if (if0.link_valid !== 1'b1) begin failures++; $display("[TB] FAIL fill_valid[%0d] actual=%b required=1", k, if0.link_valid); end
         checks++; if (if0.link_data !== 32'(k)) begin failures++; $display("[TB] FAIL fill_data[%0d] actual=%0d required=%0d", k, if0.link_data, k); end
         checks++; if (if0.credit_cnt !== CW0'(C0 - 1 - k)) begin failures++; $display("[TB] FAIL fill_cnt[%0d] actual=%0d required=%0d", k, if0.credit_cnt, C0 - 1 - k); end
         checks++; if (if0.if_full_n !== (k != C0 - 1)) begin failures++; $display("[TB] FAIL fill_full_n[%0d] actual=%b required=%b", k, if0.if_full_n, (k != C0 - 1)); end
         if0.if_din = 32'(k + 1);
      end
      cyc();
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_valid actual=%b required=0", if0.link_valid); end
      checks++; if (if0.link_data !== 32'd3) begin failures++; $display("[TB] FAIL empty_hold actual=%0d required=3", if0.link_data); end
      checks++; if (if0.credit_cnt !== CW0'(0)) begin failures++; $display("[TB] FAIL empty_cnt actual=%0d required=0", if0.credit_cnt); end
   endtask

   task automatic test_credit_return();
      if0.credit_return = 1'b1;
      cyc();
      checks++; if (if0.credit_cnt !== CW0'(1)) begin failures++; $display("[TB] FAIL ret_cnt actual=%0d required=1", if0.credit_cnt); end
      checks++; if (if0.if_full_n !== 1'b1) begin failures++; $display("[TB] FAIL ret_full_n actual=%b required=1", if0.if_full_n); end
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL ret_valid actual=%b required=0", if0.link_valid); end
      if0.credit_return = 1'b0;
      cyc();
      checks++; if (if0.link_valid !== 1'b1) begin failures++; $display("[TB] FAIL relaunch_valid actual=%b required=1", if0.link_valid); end
      checks++; if (if0.link_data !== 32'd4) begin failures++; $display("[TB] FAIL relaunch_data actual=%0d required=4", if0.link_data); end
      checks++; if (if0.credit_cnt !== CW0'(0)) begin failures++; $display("[TB] FAIL relaunch_cnt actual=%0d required=0", if0.credit_cnt); end
      checks++; if (if0.if_full_n !== 1'b0) begin failures++; $display("[TB] FAIL relaunch_full_n actual=%b required=0", if0.if_full_n); end
   endtask

   task automatic test_simultaneous();
      if0.if_write      = 1'b0;
      if0.credit_return = 1'b1;
      if0.if_din        = 32'd5;
      cyc();
      checks++; if (if0.credit_cnt !== CW0'(1)) begin failures++; $display("[TB] FAIL simul_pre_cnt actual=%0d required=1", if0.credit_cnt); end
      if0.if_write = 1'b1;
      cyc();
      checks++; if (if0.credit_cnt !== CW0'(1)) begin failures++; $display("[TB] FAIL simul_cnt actual=%0d required=1", if0.credit_cnt); end
      checks++; if (if0.if_full_n !== 1'b1) begin failures++; $display("[TB] FAIL simul_full_n actual=%b required=1", if0.if_full_n); end
      checks++; if (if0.link_valid !== 1'b1) begin failures++; $display("[TB] FAIL simul_valid actual=%b required=1", if0.link_valid); end
      checks++; if (if0.link_data !== 32'd5) begin failures++; $display("[TB] FAIL simul_data actual=%0d required=5", if0.link_data); end
      if0.if_write      = 1'b0;
      if0.credit_return = 1'b0;
      if0.if_din        = 32'd6;
      cyc();
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid actual=%b required=0", if0.link_valid); end
      checks++; if (if0.link_data !== 32'd5) begin failures++; $display("[TB] FAIL idle_hold actual=%0d required=5", if0.link_data); end
   endtask

   task automatic test_overflow();
      if0.credit_return = 1'b1;
      repeat (3) cyc();
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL refill_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
      checks++; if (if0.credit_overflow !== 1'b0) begin failures++; $display("[TB] FAIL refill_ovf actual=%b required=0", if0.credit_overflow); end
      cyc();
      checks++; if (if0.credit_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set actual=%b required=1", if0.credit_overflow); end
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL ovf_sat_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
      if0.credit_return = 1'b0;
      repeat (3) cyc();
      checks++; if (if0.credit_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky actual=%b required=1", if0.credit_overflow); end
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL ovf_hold_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
   endtask

   task automatic test_reset_midop();
      if0.if_write = 1'b1;
      if0.if_din   = 32'd10;
      cyc();
      if0.if_din = 32'd11;
      cyc();
      if0.if_din = 32'd12;
      cyc();
      checks++; if (if0.credit_cnt !== CW0'(1)) begin failures++; $display("[TB] FAIL mid_pre_cnt actual=%0d required=1", if0.credit_cnt); end
      checks++; if (if0.link_data !== 32'd12) begin failures++; $display("[TB] FAIL mid_pre_data actual=%0d required=12", if0.link_data); end
      reset = 1'b1;
      cyc();
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid actual=%b required=0", if0.link_valid); end
      checks++; if (if0.credit_cnt !== CW0'(C0)) begin failures++; $display("[TB] FAIL mid_cnt actual=%0d required=%0d", if0.credit_cnt, C0); end
      checks++; if (if0.if_full_n !== 1'b0) begin failures++; $display("[TB] FAIL mid_full_n actual=%b required=0", if0.if_full_n); end
      checks++; if (if0.credit_overflow !== 1'b0) begin failures++; $display("[TB] FAIL mid_ovf actual=%b required=0", if0.credit_overflow); end
      reset = 1'b0;
      cyc();
      checks++; if (if0.if_full_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_release_full_n actual=%b required=1", if0.if_full_n); end
      checks++; if (if0.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_release_valid actual=%b required=0", if0.link_valid); end
      if0.if_write = 1'b0;
   endtask

   task automatic test_passthrough();
      if2.if_write = 1'b1;
      if2.if_din   = 32'hA5A5_0001;
      #1;
      checks++; if (if2.link_valid !== 1'b1) begin failures++; $display("[TB] FAIL pass_valid0 actual=%b required=1", if2.link_valid); end
      checks++; if (if2.link_data !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL pass_data0 actual=%h required=a5a50001", if2.link_data); end
      cyc();
      if2.if_din = 32'hA5A5_0002;
      #1;
      checks++; if (if2.link_data !== 32'hA5A5_0002) begin failures++; $display("[TB] FAIL pass_data1 actual=%h required=a5a50002", if2.link_data); end
      checks++; if (if2.credit_cnt !== CW2'(1)) begin failures++; $display("[TB] FAIL pass_cnt1 actual=%0d required=1", if2.credit_cnt); end
      cyc();
      if2.if_din = 32'hA5A5_0003;
      #1;
      checks++; if (if2.link_valid !== 1'b0) begin failures++; $display("[TB] FAIL pass_stall_valid actual=%b required=0", if2.link_valid); end
      checks++; if (if2.link_data !== 32'hA5A5_0002) begin failures++; $display("[TB] FAIL pass_hold actual=%h required=a5a50002", if2.link_data); end
      checks++; if (if2.if_full_n !== 1'b0) begin failures++; $display("[TB] FAIL pass_full_n actual=%b required=0", if2.if_full_n); end
      if2.if_write = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] expQ[$];
      logic [31:0] logQ[$];
      logic [31:0] rxQ[$];
      bit          retQ[$];
      logic [31:0] word, lastData, popped, expData;
      int          expCnt, nextCnt, sent, cycles;
      bit          expFull, expOvf, write, acc, cr, crEff;
      int          rxErrs;

      reset = 1'b1;
      if1.if_write = 1'b0; if1.if_din = '0; if1.credit_return = 1'b0;
      repeat (2) cyc();
      reset    = 1'b0;
      expCnt   = C1;
      expFull  = 1'b0;
      expOvf   = 1'b0;
      lastData = '0;
      sent     = 0;
      cycles   = 0;
      rxErrs   = 0;
      while (sent < NumWords && cycles < MaxCycle) begin
         write = ($urandom_range(0, 3) != 0);
         word  = $urandom();
         cr    = 1'b0;
         if (rxQ.size() > 0 && $urandom_range(0, 1) == 0) begin
            popped = rxQ.pop_front();
            cr     = 1'b1;
            checks++; if (popped !== logQ[0]) begin failures++; $display("[TB] FAIL rx_order actual=%h required=%h", popped, logQ[0]); end
            void'(logQ.pop_front());
         end
         acc = write && expFull;
         if (acc) begin expQ.push_back(word); logQ.push_back(word); end
         retQ.push_back(cr);
         crEff   = (retQ.size() > PIPE1) ? retQ.pop_front() : 1'b0;
         nextCnt = expCnt - (acc ? 1 : 0) + (crEff ? 1 : 0);
         if (nextCnt > C1) begin nextCnt = C1; expOvf = 1'b1; end
         if1.if_write      = write;
         if1.if_din        = word;
         if1.credit_return = cr;
         cyc();
         cycles++;
         expCnt  = nextCnt;
         expFull = (nextCnt != 0);
         expData = acc ? expQ.pop_front() : lastData;
         lastData = expData;
         checks++; if (if1.credit_cnt !== CW0'(expCnt)) begin failures++; $display("[TB] FAIL rnd_cnt cyc=%0d actual=%0d required=%0d", cycles, if1.credit_cnt, expCnt); end
         checks++; if (if1.if_full_n !== expFull) begin failures++; $display("[TB] FAIL rnd_full_n cyc=%0d actual=%b required=%b", cycles, if1.if_full_n, expFull); end
         checks++; if (if1.link_valid !== acc) begin failures++; $display("[TB] FAIL rnd_valid cyc=%0d actual=%b required=%b", cycles, if1.link_valid, acc); end
         checks++; if (if1.link_data !== expData) begin failures++; $display("[TB] FAIL rnd_data cyc=%0d actual=%h required=%h", cycles, if1.link_data, expData); end
         checks++; if (if1.credit_overflow !== expOvf) begin failures++; $display("[TB] FAIL rnd_ovf cyc=%0d actual=%b required=%b", cycles, if1.credit_overflow, expOvf); end
         if (if1.link_valid === 1'b1) rxQ.push_back(if1.link_data);
         if (rxQ.size() > C1 && rxErrs == 0) begin
            rxErrs++;
            checks++; failures++;
            $display("[TB] FAIL rx_overflow cyc=%0d actual=%0d required<=%0d", cycles, rxQ.size(), C1);
         end
         if (acc) sent++;
      end
      if1.if_write = 1'b0; if1.credit_return = 1'b0;
      checks++; if (sent != NumWords) begin failures++; $display("[TB] FAIL rnd_timeout actual=%0d required=%0d", sent, NumWords); end
      checks++; if (if1.credit_overflow !== 1'b0) begin failures++; $display("[TB] FAIL rnd_final_ovf actual=%b required=0", if1.credit_overflow); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      if0.if_write = 1'b0; if0.if_din = '0; if0.credit_return = 1'b0;
      if1.if_write = 1'b0; if1.if_din = '0; if1.credit_return = 1'b0;
      if2.if_write = 1'b0; if2.if_din = '0; if2.credit_return = 1'b0;
      test_reset();
      test_fill();
      test_credit_return();
      test_simultaneous();
      test_overflow();
      test_reset_midop();
      test_passthrough();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
